dram_refresh_scheduler: RTL
===========================

Name: dram_refresh_scheduler

Overview:
Sequences DRAM auto-refresh: accumulates periodic refresh ticks from the refresh interval counter and tracks postponed refreshes. It requests the command bus from the read/write command path. It then issues precharge-all and one or more REFRESH commands, and enforces tRP and tRFC between them. It sits between the refresh interval counter and the command arbiter, and lets refreshes be deferred while host traffic is pending, up to a postponement limit.

Parameters:
MAX_POSTPONE, 8, max refreshes owed before refresh is forced (urgent); also saturation value of pending count
T_RP, 3, cycles from cmd_prea to earliest cmd_ref (>=1)
T_RFC, 20, cycles from cmd_ref to next cmd_ref or to bus release (>=1)
CNT_W, 4, width of pending_cnt; must hold MAX_POSTPONE

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
refresh_tick  in  1  one-cycle pulse from the interval counter; one refresh owed per pulse
host_req_pending  in  1  command path has queued read/write work
refresh_ack  in  1  command path has closed its transaction and yielded the bus; sampled only in REQ
refresh_req  out  1  scheduler requests or owns the command bus
cmd_prea  out  1  one-cycle precharge-all command strobe
cmd_ref  out  1  one-cycle REFRESH command strobe
ref_done  out  1  one-cycle pulse when each REFRESH's tRFC window expires
pending_cnt  out  CNT_W  refreshes owed
urgent  out  1  pending_cnt == MAX_POSTPONE
overflow_err  out  1  sticky: tick arrived while pending_cnt already at MAX_POSTPONE

Behaviour:
- Reset: all outputs 0, state IDLE, timer 0. This also applies to reset mid-sequence: on the cycle after rst, no strobes and refresh_req=0.
- All outputs registered. Decisions use registered pending_cnt and urgent.
- pending_cnt update:
  - +1 on refresh_tick.
  - -1 in the cycle cmd_ref is asserted; the decrement is visible the next cycle.
  - tick and cmd_ref in the same cycle: unchanged.
  - tick at MAX_POSTPONE without cmd_ref: count stays saturated and overflow_err sets; it is cleared only by rst.
- go condition: pending_cnt != 0 AND (host_req_pending == 0 OR urgent).
- States:
  - IDLE: if go, enter REQ next cycle.
  - REQ: refresh_req=1. If refresh_ack=1, enter PRE next cycle; otherwise wait indefinitely. go is not re-evaluated here.
  - PRE: cmd_prea=1 for exactly one cycle; load timer; enter WAIT_RP.
  - WAIT_RP: cmd_ref is asserted exactly T_RP cycles after the cmd_prea cycle (REF state).
  - REF: cmd_ref=1 for one cycle; load timer; enter WAIT_RFC.
  - WAIT_RFC: in the cycle T_RFC after cmd_ref, ref_done=1. In that same cycle:
    - if go: cmd_ref=1 again (burst). No new precharge; refresh_req stays 1.
    - else: refresh_req=0, return to IDLE.
- refresh_req is 1 in every cycle from REQ entry through the final WAIT_RFC expiry (exclusive).
- cmd_prea and cmd_ref are never asserted in the same cycle. No cmd_ref is ever issued without a preceding cmd_prea in the same ownership window.
- refresh_ack outside REQ is ignored. refresh_tick is accepted in every state.

Test Plan:
- Single tick, host idle, refresh_ack tied 1, defaults. Tick at cycle 0 → pending_cnt=1 @1, refresh_req=1 @2, cmd_prea @3, cmd_ref @6, pending_cnt=0 @7, ref_done=1 and refresh_req=0 @26.
- Postponement: host_req_pending=1, 3 ticks → pending_cnt=3, refresh_req stays 0. Drop host_req_pending → one cmd_prea, then 3 cmd_ref spaced exactly 20 cycles, 3 ref_done pulses, refresh_req low at the last ref_done, pending_cnt=0.
- Urgent: host_req_pending held 1, 8 ticks → urgent=1, refresh_req rises. One cmd_ref issued → pending_cnt=7, urgent=0. Scheduler returns to IDLE at ref_done.
- Overflow: refresh_ack held 0, 9 ticks → pending_cnt=8, overflow_err=1. overflow_err stays 1 after refreshes drain; cleared only by rst.
- Simultaneous: refresh_tick in the same cycle as cmd_ref with pending_cnt=2 → pending_cnt remains 2.
- Reset mid-op: assert rst during WAIT_RFC → next cycle refresh_req, strobes, pending_cnt, urgent, overflow_err all 0. No cmd_ref follows with zero ticks.

Source files
------------

// File: rtl/dram_refresh_scheduler.sv
// -----------------------------------------------------------------------------
// dram_refresh_scheduler
//
// Purpose:
//   Sequences DRAM auto-refresh. Periodic refresh ticks are accumulated into a
//   count of refreshes owed. While host traffic is pending, refreshes are
//   postponed until the owed count reaches MAX_POSTPONE (urgent). When a
//   refresh is allowed, the scheduler requests the command bus, waits for the
//   command path to yield, issues one precharge-all, then one or more REFRESH
//   commands. It holds tRP between the precharge and the first REFRESH, and
//   tRFC after every REFRESH.
//
// Ports:
//   clk              in   clock
//   rst              in   synchronous active-high reset
//   refresh_tick     in   one-cycle pulse, one refresh owed per pulse
//   host_req_pending in   command path has queued read/write work
//   refresh_ack      in   command path has yielded the bus (used only in REQ)
//   refresh_req      out  scheduler requests or owns the command bus
//   cmd_prea         out  one-cycle precharge-all strobe
//   cmd_ref          out  one-cycle REFRESH strobe
//   ref_done         out  one-cycle pulse when a REFRESH's tRFC window expires
//   pending_cnt      out  refreshes owed (saturates at MAX_POSTPONE)
//   urgent           out  pending_cnt == MAX_POSTPONE
//   overflow_err     out  sticky: tick arrived while already saturated
//
// Every output is a flop. Next-state decisions are made from the registered
// pending_cnt/urgent, so a tick only influences scheduling one cycle after it
// has been counted.
// -----------------------------------------------------------------------------
module dram_refresh_scheduler #(
    parameter int MAX_POSTPONE = 8,
    parameter int T_RP         = 3,
    parameter int T_RFC        = 20,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             refresh_tick,
    input  logic             host_req_pending,
    input  logic             refresh_ack,
    output logic             refresh_req,
    output logic             cmd_prea,
    output logic             cmd_ref,
    output logic             ref_done,
    output logic [CNT_W-1:0] pending_cnt,
    output logic             urgent,
    output logic             overflow_err
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_REQ      = 3'd1;
    localparam logic [2:0] ST_PRE      = 3'd2;
    localparam logic [2:0] ST_WAIT_RP  = 3'd3;
    localparam logic [2:0] ST_REF      = 3'd4;
    localparam logic [2:0] ST_WAIT_RFC = 3'd5;

    // Timer is wide enough for the longer of the two windows.
    localparam int T_MAX = (T_RP > T_RFC) ? T_RP : T_RFC;
    localparam int TMR_W = $clog2(T_MAX + 1);

    // The timer is loaded in the strobe cycle and the wait ends when it reads
    // 1, so the next command lands exactly T_x cycles after the strobe.
    localparam logic [TMR_W-1:0] RP_LOAD  = TMR_W'(T_RP - 1);
    localparam logic [TMR_W-1:0] RFC_LOAD = TMR_W'(T_RFC - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_POSTPONE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // With a one-cycle window the wait state is skipped entirely.
    localparam logic RP_IS_ONE  = (T_RP == 1);
    localparam logic RFC_IS_ONE = (T_RFC == 1);

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [2:0]       state_q,        state_d;
    logic [TMR_W-1:0] timer_q,        timer_d;
    logic [CNT_W-1:0] pending_cnt_q,  pending_cnt_d;
    logic             urgent_q,       urgent_d;
    logic             overflow_q,     overflow_d;
    logic             refresh_req_q,  refresh_req_d;
    logic             cmd_prea_q,     cmd_prea_d;
    logic             cmd_ref_q,      cmd_ref_d;
    logic             ref_done_q,     ref_done_d;

    // -------------------------------------------------------------------------
    // Scheduling decision
    // -------------------------------------------------------------------------
    logic go;
    logic rp_expire;
    logic rfc_expire;

    // Refresh is allowed when something is owed and either the host is quiet
    // or the postponement budget is exhausted.
    assign go = (pending_cnt_q != '0) && (!host_req_pending || urgent_q);

    // Last cycle of the tRP window: next cycle issues REFRESH.
    assign rp_expire  = ((state_q == ST_PRE)      && RP_IS_ONE) ||
                        ((state_q == ST_WAIT_RP)  && (timer_q == TMR_ONE));

    // Last cycle of the tRFC window: next cycle carries ref_done and either a
    // burst REFRESH or the bus release.
    assign rfc_expire = ((state_q == ST_REF)      && RFC_IS_ONE) ||
                        ((state_q == ST_WAIT_RFC) && (timer_q == TMR_ONE));

    // -------------------------------------------------------------------------
    // FSM next-state and timer
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        ref_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_REQ;
                end
            end

            // go is deliberately not re-checked here: once the bus has been
            // requested the sequence is committed until the command path yields.
            ST_REQ: begin
                if (refresh_ack) begin
                    state_d = ST_PRE;
                end
            end

            ST_PRE: begin
                timer_d = RP_LOAD;
                state_d = rp_expire ? ST_REF : ST_WAIT_RP;
            end

            ST_WAIT_RP: begin
                if (rp_expire) begin
                    state_d = ST_REF;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end

            ST_REF: begin
                timer_d = RFC_LOAD;
                if (rfc_expire) begin
                    ref_done_d = 1'b1;
                    state_d    = go ? ST_REF : ST_IDLE;
                end else begin
                    state_d    = ST_WAIT_RFC;
                end
            end

            ST_WAIT_RFC: begin
                if (rfc_expire) begin
                    ref_done_d = 1'b1;
                    // Burst another REFRESH without a new precharge while the
                    // bus is still owned; otherwise release it.
                    state_d    = go ? ST_REF : ST_IDLE;
                end else begin
                    timer_d    = timer_q - TMR_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Outputs are registered copies of the decoded next state, so each strobe
    // appears in the same cycle the FSM occupies the matching state.
    always_comb begin
        refresh_req_d = (state_d != ST_IDLE);
        cmd_prea_d    = (state_d == ST_PRE);
        cmd_ref_d     = (state_d == ST_REF);
    end

    // -------------------------------------------------------------------------
    // Owed-refresh counter
    // -------------------------------------------------------------------------
    // A tick and a REFRESH in the same cycle cancel. A tick that cannot be
    // counted because the counter is saturated is recorded as a sticky error.
    always_comb begin
        pending_cnt_d = pending_cnt_q;
        overflow_d    = overflow_q;

        if (refresh_tick && !cmd_ref_q) begin
            if (pending_cnt_q == CNT_MAX) begin
                overflow_d    = 1'b1;
            end else begin
                pending_cnt_d = pending_cnt_q + CNT_ONE;
            end
        end else if (cmd_ref_q && !refresh_tick) begin
            if (pending_cnt_q != '0) begin
                pending_cnt_d = pending_cnt_q - CNT_ONE;
            end
        end

        urgent_d = (pending_cnt_d == CNT_MAX);
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            pending_cnt_q <= '0;
            urgent_q      <= 1'b0;
            overflow_q    <= 1'b0;
            refresh_req_q <= 1'b0;
            cmd_prea_q    <= 1'b0;
            cmd_ref_q     <= 1'b0;
            ref_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            pending_cnt_q <= pending_cnt_d;
            urgent_q      <= urgent_d;
            overflow_q    <= overflow_d;
            refresh_req_q <= refresh_req_d;
            cmd_prea_q    <= cmd_prea_d;
            cmd_ref_q     <= cmd_ref_d;
            ref_done_q    <= ref_done_d;
        end
    end

    assign refresh_req  = refresh_req_q;
    assign cmd_prea     = cmd_prea_q;
    assign cmd_ref      = cmd_ref_q;
    assign ref_done     = ref_done_q;
    assign pending_cnt  = pending_cnt_q;
    assign urgent       = urgent_q;
    assign overflow_err = overflow_q;

endmodule
